// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel used by the fetch stage.
// One request outstanding at a time; one response per grant.
interface fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and
// presents {pc, inst, pc+4} to IF/ID, or a NOP bubble when nothing is ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_stall,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  o_pcF,
  output logic [31:0]  o_instF,
  output logic [31:0]  o_pc_fourF,
  output logic         o_validF
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] buf_q;
  logic [31:0] buf_d;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        gnt;
  logic        rsp;
  logic        unused_lsb;

  assign tgt        = {i_redirect_pc[31:2], 2'b00};
  assign unused_lsb = ^i_redirect_pc[1:0];
  assign pc_inc     = pc_q + 32'd4;
  assign gnt        = imem.i_imem_gnt;
  assign rsp        = imem.i_imem_rvalid;

  assign imem.o_imem_req  = (state_q == REQ);
  assign imem.o_imem_addr = pc_q;
  assign o_pcF            = pc_q;
  assign o_pc_fourF       = pc_inc;

  // A redirect always kills whatever would be presented this cycle.
  always_comb begin
    o_validF = 1'b0;
    o_instF  = NOP_INST;
    if (!i_redirect) begin
      unique case (1'b1)
        (state_q == WAIT) && rsp: begin
          o_validF = 1'b1;
          o_instF  = imem.i_imem_rdata;
        end
        (state_q == HOLD): begin
          o_validF = 1'b1;
          o_instF  = buf_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (i_redirect) begin
          pc_d = tgt;
          if (gnt) state_d = DROP;
        end else if (gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          pc_d    = tgt;
          state_d = rsp ? REQ : DROP;
        end else if (rsp) begin
          if (!i_stall) begin
            pc_d    = pc_inc;
            state_d = REQ;
          end else begin
            buf_d   = imem.i_imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_redirect) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (!i_stall) begin
          pc_d    = pc_inc;
          state_d = REQ;
        end
      end
      DROP: begin
        if (i_redirect) pc_d = tgt;
        if (rsp) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios, then random
// stall/redirect/grant/latency traffic against a program-order PC model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pcF;
  logic [31:0] instF;
  logic [31:0] pc_fourF;
  logic        validF;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (RPC),
    .NOP_INST (NOP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .imem          (imem),
    .o_pcF         (pcF),
    .o_instF       (instF),
    .o_pc_fourF    (pc_fourF),
    .o_validF      (validF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_cfg = 1;
  rsp_t        mem_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] model_pc;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_inst;

  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle after the edge; the memory answers from its queue.
  task automatic step(input bit s, input bit r, input logic [31:0] rp,
                      input bit g, input bit rs);
    @(posedge clk);
    #1;
    cyc++;
    stall            = s;
    redirect         = r;
    redirect_pc      = rp;
    imem.i_imem_gnt  = g;
    rst_n            = rs;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem.i_imem_rvalid = 1'b1;
      imem.i_imem_rdata  = code(mem_q[0].addr);
    end else begin
      imem.i_imem_rvalid = 1'b0;
      imem.i_imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
  endtask

  // Monitor: program-order model plus expected-fetch scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_pc  = RPC;
      hold_prev = 1'b0;
      sb_q.delete();
      if (imem.i_imem_rvalid && mem_q.size() > 0)
        void'(mem_q.pop_front());
    end else begin
      chk("pc", pcF, model_pc);
      chk("pc_four", pc_fourF, model_pc + 32'd4);
      chk("addr", imem.o_imem_addr, model_pc);
      if (redirect) chk1("redir_kill", validF, 1'b0);
      if (!validF) chk("bubble", instF, NOP);
      if (hold_prev && !redirect) begin
        chk1("hold_valid", validF, 1'b1);
        chk("hold_inst", instF, hold_inst);
        chk1("hold_noreq", imem.o_imem_req, 1'b0);
      end
      if (imem.i_imem_rvalid && mem_q.size() > 0)
        void'(mem_q.pop_front());
      if (imem.o_imem_req && imem.i_imem_gnt) begin
        chk("single_out", mem_q.size(), 0);
        mem_q.push_back('{addr: imem.o_imem_addr, due: cyc + lat_cfg});
        if (!redirect) sb_q.push_back(model_pc);
      end
      if (validF && !stall && !redirect) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected: got pc %h expected none", pcF);
        end else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          chk("acc_pc", pcF, e);
          chk("acc_inst", instF, code(e));
        end
        acc_q.push_back(pcF);
        model_pc = model_pc + 32'd4;
      end
      if (redirect) begin
        model_pc = {redirect_pc[31:2], 2'b00};
        sb_q.delete();
      end
      hold_prev = validF && stall && !redirect;
      hold_inst = instF;
    end
  end

  initial begin
    rst_n              = 1'b0;
    stall              = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = 32'h0;
    imem.i_imem_gnt    = 1'b0;
    imem.i_imem_rvalid = 1'b0;
    imem.i_imem_rdata  = 32'h0;

    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk1("rst_req", imem.o_imem_req, 1'b0);
    chk1("rst_valid", validF, 1'b0);
    chk("rst_inst", instF, NOP);
    chk("rst_pc", pcF, RPC);
    chk("rst_pc4", pc_fourF, 32'h0);

    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk1("first_req", imem.o_imem_req, 1'b1);
    chk("first_addr", imem.o_imem_addr, RPC);

    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 1);
      chk1("alt_valid", validF, (i % 2) == 0);
    end
    chk1("req_8", imem.o_imem_req, 1'b1);
    chk("addr_8", imem.o_imem_addr, 32'h8);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      chk1("stall_valid", validF, 1'b1);
      chk("stall_inst", instF, code(32'h8));
      chk1("stall_noreq", imem.o_imem_req, 1'b0);
    end
    step(0, 0, 0, 1, 1);
    chk1("release_valid", validF, 1'b1);
    lat_cfg = 3;
    step(0, 0, 0, 1, 1);
    chk1("req_c", imem.o_imem_req, 1'b1);
    chk("addr_c", imem.o_imem_addr, 32'hC);
    chk("wrap_pc", acc_q[1], 32'h0);
    chk("acc_8", acc_q[3], 32'h8);

    step(0, 1, 32'h100, 1, 1);
    chk1("wait_redir_valid", validF, 1'b0);
    step(0, 0, 0, 1, 1);
    chk1("drop_valid", validF, 1'b0);
    chk1("drop_noreq", imem.o_imem_req, 1'b0);
    step(0, 0, 0, 1, 1);
    chk1("late_rsp_hidden", validF, 1'b0);
    lat_cfg = 1;
    step(0, 0, 0, 1, 1);
    chk("addr_100", imem.o_imem_addr, 32'h100);
    step(0, 0, 0, 1, 1);
    chk1("valid_100", validF, 1'b1);
    chk("pc_100", pcF, 32'h100);

    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h203, 1, 1);
    chk1("coinc_kill", validF, 1'b0);
    lat_cfg = 2;
    step(0, 0, 0, 1, 1);
    chk1("req_200", imem.o_imem_req, 1'b1);
    chk("addr_200", imem.o_imem_addr, 32'h200);

    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk1("stray_seen", imem.i_imem_rvalid, 1'b1);
    chk1("mrst_req", imem.o_imem_req, 1'b0);
    chk1("mrst_valid", validF, 1'b0);
    chk("mrst_inst", instF, NOP);
    chk("mrst_pc", pcF, RPC);
    lat_cfg = 1;
    step(0, 0, 0, 1, 1);
    chk1("mrst_req2", imem.o_imem_req, 1'b1);
    chk("mrst_addr", imem.o_imem_addr, RPC);
    step(0, 0, 0, 1, 1);
    chk("mrst_inst2", instF, code(RPC));

    for (int i = 0; i < 3000; i++) begin
      lat_cfg = $urandom_range(1, 3);
      step(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom,
           ($urandom % 10) < 6, 1);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
    chk1("progress", acc_q.size() > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that drives the IF/ID pipeline register: owns the PC, issues single-outstanding requests to instruction memory, and presents `{pc, inst, pc+4}` to IF/ID. It consumes the same stall signal as IF/ID and the branch/jump redirect from EX. When no instruction is ready, it emits a NOP bubble so IF/ID never re-latches stale data.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC after reset.
- `NOP_INST`, default `32'h0000_0013`: bubble instruction presented when no valid fetch.
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_stall`, in, 1: hazard-unit stall; the same signal feeds IF/ID.
- `i_redirect`, in, 1: taken branch/jump from EX.
- `i_redirect_pc`, in, 32: redirect target; bits [1:0] are ignored and forced to 0.
- `o_imem_req`, out, 1: fetch request valid.
- `o_imem_addr`, out, 32: fetch address (current PC).
- `i_imem_gnt`, in, 1: request accepted when `o_imem_req && i_imem_gnt`.
- `i_imem_rvalid`, in, 1: read data valid. Earliest assertion is the cycle after grant; exactly one response per grant.
- `i_imem_rdata`, in, 32: instruction word.
- `o_pcF`, out, 32: PC of the presented instruction.
- `o_instF`, out, 32: presented instruction, or `NOP_INST` when `o_validF=0`.
- `o_pc_fourF`, out, 32: `o_pcF + 4`, modulo 2^32.
- `o_validF`, out, 1: `o_instF` is a real fetched instruction.

## Operation
- PC register, 32-bit. Increment is `+4` with wrap from `32'hFFFF_FFFC` to `0`.
- At most one memory transaction is outstanding.
- States:
  - IDLE: post-reset only.
  - REQ: `o_imem_req=1`, waiting for `gnt`.
  - WAIT: granted, waiting for `rvalid`.
  - HOLD: instruction buffered, waiting for acceptance.
  - DROP: granted response must be discarded.
- Acceptance: an instruction is consumed at an edge where `o_validF=1 && i_stall=0 && i_redirect=0`.
- Transitions (redirect has top priority everywhere):
  - IDLE → REQ unconditionally.
  - REQ, `gnt=1`:
    - With redirect: PC ← target, go to DROP.
    - Without redirect: go to WAIT.
  - REQ, `gnt=0`:
    - With redirect: PC ← target, stay in REQ. The address changes while ungranted, which the memory must tolerate.
  - WAIT:
    - `rvalid=0`: stay. With redirect: PC ← target, go to DROP.
    - `rvalid=1` and redirect: discard the data, PC ← target, go to REQ.
    - `rvalid=1` and consumed: PC ← PC+4, go to REQ.
    - `rvalid=1` and stalled: capture `rdata` into the buffer, go to HOLD.
  - HOLD:
    - Redirect: discard the buffer, PC ← target, go to REQ.
    - Consumed: PC ← PC+4, go to REQ.
    - Otherwise stay; the buffer is stable.
  - DROP:
    - `rvalid=1`: discard the data, go to REQ. With a simultaneous redirect, PC ← target as well.
    - `rvalid=0` with redirect: PC ← target, stay in DROP.
- Output mux:
  - WAIT with `rvalid=1`: `o_validF=1`, `o_instF=i_imem_rdata` (combinational bypass).
  - HOLD: `o_validF=1`, `o_instF=buffer`.
  - All other cases: `o_validF=0`, `o_instF=NOP_INST`.
  - Outputs are forced invalid in any cycle with `i_redirect=1`.
- `o_pcF` = PC in all states. `o_imem_addr` = PC.
- Unconsumed bubbles (`o_validF=0`, `i_stall=0`) carry no state change. IF/ID latches the NOP.

## Timing
- Reset (edge sampled with `i_rst_n=0`), regardless of state or outstanding transaction:
  - State = IDLE, PC = `RESET_PC`, buffer = `NOP_INST`.
  - `o_imem_req=0`, `o_validF=0`, `o_instF=NOP_INST`.
  - `o_pcF=RESET_PC`, `o_pc_fourF=RESET_PC+4`.
- A response arriving in IDLE after a mid-transaction reset is ignored.
- First request: `o_imem_req=1` in the cycle after reset deasserts.
- Best-case latency, grant to presented instruction: 1 cycle (rvalid bypass).
- Sustained throughput: 1 instruction per 2 cycles (REQ→WAIT→REQ) with zero-wait memory.
- Redirect → new address on `o_imem_addr`:
  - Next cycle, from REQ/WAIT-with-rvalid/HOLD.
  - After the pending response, from WAIT/DROP.

## Test plan
- Reset, zero-wait memory returning `inst=addr^32'hA5A5_0000`, `i_stall=0`:
  - Required: `o_validF` pulses every 2nd cycle with `o_pcF` = 0, 4, 8, …, each paired with the matching inst and `o_pc_fourF=o_pcF+4`.
- Stall held 3 cycles while `rvalid` arrives for PC `0x8`:
  - Required: HOLD keeps `o_instF` stable and `o_validF=1`, with no new `o_imem_req`.
  - After release, the next request is to `0xC`.
- Redirect to `0x100` while in WAIT (granted, `rvalid` 2 cycles later):
  - Required: the late response is never presented (`o_validF=0`).
  - The next request address is `0x100`, and the next valid `o_pcF=0x100`.
- Redirect coincident with `rvalid` and `i_stall=0`:
  - Required: the instruction is discarded and `o_validF=0` that cycle.
  - The next request is to `redirect_pc & ~3` (target `0x203` → `0x200`).
- PC wrap and reset mid-WAIT:
  - `RESET_PC=32'hFFFF_FFFC` → the second fetch address is `0x0`.
  - Assert `i_rst_n=0` during WAIT with `rvalid` the following cycle → outputs at reset values and the stray data is ignored.
